// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             bit_d, bit_bout;
   logic             last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Operands shift right so the bit under work is always at position 0.
   fs_bit u_fs_bit (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (bit_d),
      .bout (bit_bout)
   );

   assign last = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_d   = ovf_q;
`endif
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               state_d = SHIFT;
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               diff_d  = '0;
               bout_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               ovf_d   = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = bit_bout;
            diff_d = {bit_d, diff_q[WIDTH-1:1]};
            if (last) begin
               state_d = DONE;
               bout_d  = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               // On the last bit a_q[0]/b_q[0] are the operand sign bits.
               ovf_d   = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         br_q   <= 1'b0;
         diff_q <= '0;
         cnt_q  <= '0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         br_q   <= br_d;
         diff_q <= diff_d;
         cnt_q  <= cnt_d;
         bout_q <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have ports, one per line, clock and reset first:
  clk    input   1      single clock, rising edge
  rst_n  input   1      reset, asynchronous, active-low
  start  input   1      request to begin a subtraction
  a      input   WIDTH  minuend, sampled on accepted start
  b      input   WIDTH  subtrahend, sampled on accepted start
  bin    input   1      borrow-in, sampled on accepted start
  busy   output  1      high while in SHIFT
  done   output  1      one-cycle pulse, result valid
  diff   output  WIDTH  a - b - bin modulo 2^WIDTH
  bout   output  1      borrow-out: 1 iff a < b + bin (unsigned)
REQ-003 SHALL use one clock (clk); reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-005 IDLE: start=1 at edge -> load a, b, bin into shift/borrow registers, clear bit counter, go SHIFT.
REQ-006 SHIFT: each edge processes one bit, LSB first: d = a0 ^ b0 ^ br; br' = (~a0 & b0) | (~(a0 ^ b0) & br); d shifts into diff MSB end; counter increments.
REQ-007 SHIFT -> DONE on the edge processing bit WIDTH-1 (exactly WIDTH SHIFT edges).
REQ-008 done SHALL be 1 only in DONE, for one cycle; latency from start-capture edge to done high = WIDTH cycles.
REQ-009 diff and bout SHALL be valid in DONE and hold until the next accepted start.
REQ-010 DONE -> IDLE when start=0; DONE with start=1 SHALL accept new operands and go SHIFT (back-to-back, no idle cycle).
REQ-011 start in SHIFT SHALL be ignored; operands SHALL not change mid-operation.
REQ-012 busy SHALL be 1 exactly in SHIFT.
REQ-013 bit counter width SHALL be $clog2(WIDTH); it SHALL not wrap within an operation.

Reset
REQ-014 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, counter=0, internal registers=0.
REQ-015 reset mid-SHIFT SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-016 first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-017 macro SERIAL_SUBTRACTOR_OVF_EN defined: extra output ovf (1 bit) = signed overflow, (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), valid with diff, reset 0.
REQ-018 macro undefined: no ovf port, no related logic; all other behaviour identical.

Structure
REQ-019 package serial_subtractor_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-020 per-bit difference/borrow logic SHALL be a combinational sub-module fs_bit (inputs a, b, bin; outputs d, bout), instantiated once.

Verification (WIDTH=8)
REQ-021 a=0x5A, b=0x23, bin=0 -> after 8 cycles done=1, diff=0x37, bout=0, busy high 8 cycles.
REQ-022 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-023 with SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-024 start pulsed during SHIFT with other operands -> ignored, result matches first operands, single done.
REQ-025 rst_n low at 4th SHIFT cycle -> outputs 0 immediately, no done after release; next start gives correct result.
REQ-026 start held high through DONE with new operands -> second op begins immediately, second done exactly 9 cycles after the first done.
